// File: rtl/int_pkg.sv
// int_pkg: shared constants and types for the interrupt controller.
//   - FSM state encoding (IDLE/TAKE/SERVE, 2 bits)
//   - source index constants (bit position of each line in the masks)
//   - default program counter width and ISR entry vectors
//   - reti_clear(): drops the highest-priority in-service source
package int_pkg;

  localparam int unsigned PC_W_DEF = 10;

  localparam int unsigned SRC_INTR1 = 0;
  localparam int unsigned SRC_INTR2 = 1;

  localparam logic [PC_W_DEF-1:0] VEC1_DEF = 10'h3F0;
  localparam logic [PC_W_DEF-1:0] VEC2_DEF = 10'h3F8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TAKE  = 2'd1,
    ST_SERVE = 2'd2
  } state_e;

  // Return from the innermost ISR: bit0 (intr1) outranks bit1 (intr2).
  function automatic logic [1:0] reti_clear(input logic [1:0] in_svc);
    logic [1:0] res;
    res = in_svc;
    if (in_svc[SRC_INTR1]) res[SRC_INTR1] = 1'b0;
    else                   res[SRC_INTR2] = 1'b0;
    return res;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// int_ctrl_if: request/mask/return inputs and take/vector/status outputs
// exchanged between the control unit (master) and int_ctrl (slave).
//   intr1/intr2   raw request lines (asynchronous)
//   ie_we/ie_data enable-mask write
//   reti          return-from-interrupt pulse
//   int_take      one-cycle take pulse, int_vec its ISR entry address
//   ie/pending/in_service  controller status
interface int_ctrl_if #(
  parameter int unsigned PC_W = 10
) ();

  logic            intr1;
  logic            intr2;
  logic            ie_we;
  logic [1:0]      ie_data;
  logic            reti;
  logic            int_take;
  logic [PC_W-1:0] int_vec;
  logic [1:0]      ie;
  logic [1:0]      pending;
  logic [1:0]      in_service;

  modport master (
    output intr1, intr2, ie_we, ie_data, reti,
    input  int_take, int_vec, ie, pending, in_service
  );

  modport slave (
    input  intr1, intr2, ie_we, ie_data, reti,
    output int_take, int_vec, ie, pending, in_service
  );

endinterface

// File: rtl/int_sync_edge.sv
// int_sync_edge: 2-flop synchroniser followed by a rising-edge detector.
//   clk     system clock
//   reset   asynchronous, active-high
//   din     raw asynchronous input
//   rise_c  combinational one-cycle pulse when the synchronised level rises
module int_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise_c
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic prev_q, prev_d;

  always_comb begin
    s1_d   = din;
    s2_d   = s1_q;
    prev_d = s2_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
    end
  end

  // Left combinational so raw rise -> pending costs exactly three edges.
  assign rise_c = s2_q & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// int_ctrl: two-source interrupt controller for the single-cycle CPU.
// Latches synchronised request edges, masks them with ie, arbitrates with
// intr1 first, issues a one-cycle int_take with int_vec, and tracks the
// active ISRs until reti.
//   clk, reset  clock and asynchronous active-high reset
//   bus         int_ctrl_if slave modport (requests, mask, reti, status)
// Optional: define INT_NEST_EN to let intr1 preempt a running intr2 ISR.
module int_ctrl
  import int_pkg::*;
#(
  parameter int unsigned     PC_W = PC_W_DEF,
  parameter logic [PC_W-1:0] VEC1 = VEC1_DEF,
  parameter logic [PC_W-1:0] VEC2 = VEC2_DEF
) (
  input  logic         clk,
  input  logic         reset,
  int_ctrl_if.slave    bus
);

  logic [1:0] rise_c;

  int_sync_edge u_sync_intr1 (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.intr1),
    .rise_c (rise_c[SRC_INTR1])
  );

  int_sync_edge u_sync_intr2 (
    .clk    (clk),
    .reset  (reset),
    .din    (bus.intr2),
    .rise_c (rise_c[SRC_INTR2])
  );

  state_e          state_q, state_d;
  logic [1:0]      ie_q, ie_d;
  logic [1:0]      pend_q, pend_d;
  logic [1:0]      insv_q, insv_d;
  logic            take_q, take_d;
  logic [PC_W-1:0] vec_q, vec_d;
  logic            win_q, win_d;

  logic [1:0]      blocked_c;
  logic [1:0]      eligible_c;
  logic            win_c;
  logic [1:0]      pend_clr_c;

  // Arbitration: which latched requests may be taken right now.
  always_comb begin
`ifdef INT_NEST_EN
    blocked_c = insv_q | {insv_q[SRC_INTR1], 1'b0};
`else
    blocked_c = (insv_q != 2'b00) ? 2'b11 : 2'b00;
`endif
    eligible_c = pend_q & ie_q & ~blocked_c;
    // 0 selects intr1, 1 selects intr2.
    win_c      = ~eligible_c[SRC_INTR1];
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    ie_d       = bus.ie_we ? bus.ie_data : ie_q;
    insv_d     = insv_q;
    take_d     = 1'b0;
    vec_d      = vec_q;
    win_d      = win_q;
    pend_clr_c = 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        if (eligible_c != 2'b00) begin
          state_d = ST_TAKE;
          take_d  = 1'b1;
          win_d   = win_c;
          vec_d   = win_c ? VEC2 : VEC1;
        end
      end
      ST_TAKE: begin
        state_d           = ST_SERVE;
        pend_clr_c[win_q] = 1'b1;
        insv_d[win_q]     = 1'b1;
      end
      ST_SERVE: begin
        if (bus.reti) begin
          insv_d = reti_clear(insv_q);
          if (insv_d == 2'b00) state_d = ST_IDLE;
        end else if (eligible_c != 2'b00) begin
          // Only reachable with nesting: intr1 preempting an intr2 ISR.
          state_d = ST_TAKE;
          take_d  = 1'b1;
          win_d   = win_c;
          vec_d   = win_c ? VEC2 : VEC1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A new edge in the same cycle as the clear keeps the request.
    pend_d = (pend_q & ~pend_clr_c) | rise_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ie_q    <= 2'b00;
      pend_q  <= 2'b00;
      insv_q  <= 2'b00;
      take_q  <= 1'b0;
      vec_q   <= '0;
      win_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ie_q    <= ie_d;
      pend_q  <= pend_d;
      insv_q  <= insv_d;
      take_q  <= take_d;
      vec_q   <= vec_d;
      win_q   <= win_d;
    end
  end

  assign bus.int_take   = take_q;
  assign bus.int_vec    = vec_q;
  assign bus.ie         = ie_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = insv_q;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Interrupt controller for the single-cycle CPU; sequences entry to and exit from interrupt service routines for the two external lines intr1/intr2.
- Synchronises and latches requests, applies the enable mask, arbitrates with fixed priority, and issues a one-cycle take pulse plus vector to the control unit/PC mux.
- Tracks in-service state until the control unit signals return-from-interrupt.

Parameters:
PC_W, 10, width of program counter / vector.
VEC1, 10'h3F0, ISR entry address for intr1.
VEC2, 10'h3F8, ISR entry address for intr2.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
intr1  in  1  raw external request line 1, asynchronous to clk, highest priority.
intr2  in  1  raw external request line 2, asynchronous to clk.
ie_we  in  1  write strobe for enable mask.
ie_data  in  2  new mask; bit0 = intr1, bit1 = intr2.
reti  in  1  one-cycle pulse from control unit when RETI is decoded.
int_take  out  1  one-cycle pulse; control unit suppresses we3/wez/we4/we_out, pushes current PC, loads int_vec.
int_vec  out  PC_W  vector of the source being taken; holds last value otherwise.
ie  out  2  current enable mask.
pending  out  2  latched, not-yet-taken requests.
in_service  out  2  sources whose ISR is active.

Behaviour:
- Reset (async): state IDLE; ie=0, pending=0, in_service=0, int_take=0, int_vec=0, synchroniser flops=0.
- Input path: each line goes through a 2-flop synchroniser and rising-edge detector; a detected edge sets its pending bit. Latency from raw rise to pending=1 is 3 clk edges.
- Level held high sets pending once only; re-arming needs a low then a new rise.
- Masked sources still latch pending; they are only excluded from arbitration.
- ie_we loads ie from ie_data on the next edge; the new mask takes effect for arbitration from the following cycle.
- eligible = pending & ie & ~blocked.
  - Without nesting: blocked = 2'b11 whenever in_service != 0.
  - bit0 has priority over bit1.
- FSM states: IDLE, TAKE, SERVE.
  - IDLE: eligible != 0 -> TAKE (registered decision, winner captured in this cycle).
  - TAKE: one cycle. int_take=1; int_vec=VEC1 or VEC2 of the winner; the winner's pending bit clears and its in_service bit sets at the end of the cycle. Always goes to SERVE.
  - SERVE: reti clears the highest-priority set in_service bit. If the result is 0 -> IDLE, otherwise stay in SERVE.
- Pending set and clear in the same cycle (new edge during TAKE of the same source): set wins.
- reti in IDLE or TAKE is ignored.
- Both sources become eligible on the same cycle: intr1 is taken; intr2 stays pending and is taken after the return to IDLE (minimum 1 idle cycle between TAKE pulses).
- int_take is never asserted on two consecutive cycles.
- Reset mid-ISR or mid-TAKE clears everything immediately. Lost requests are acceptable.

Optional Feature:
- Macro: INT_NEST_EN.
- Defined:
  - In SERVE with in_service==2'b10, an eligible intr1 -> TAKE (preempts the intr2 ISR). blocked = in_service | {in_service[0], 1'b0}, so intr1 is never blocked by intr2.
  - The first reti clears bit0 and stays in SERVE; the second clears bit1 -> IDLE.
- Undefined: no preemption; any active ISR blocks all sources.

Decomposition:
- Package int_pkg:
  - state encoding constants (IDLE/TAKE/SERVE, 2 bits);
  - source index constants (SRC_INTR1=0, SRC_INTR2=1);
  - default vector constants.
- Sub-module int_sync_edge: 2-flop synchroniser + rising-edge detector with async active-high reset, instantiated once per line.

Test Plan:
- Reset, ie=2'b01, pulse intr1 -> pending[0]=1 after 3 edges; next cycles: int_take=1 for one cycle, int_vec=10'h3F0, in_service=2'b01, pending=0.
- ie=2'b00, pulse intr2 -> pending=2'b10, no int_take. Then write ie=2'b10 -> TAKE with int_vec=10'h3F8.
- ie=2'b11, raise intr1 and intr2 in the same cycle -> first take vec 10'h3F0. reti -> IDLE, then second take vec 10'h3F8; in_service=0 after the final reti.
- In SERVE for intr2, pulse intr1:
  - without INT_NEST_EN, no take until reti;
  - with INT_NEST_EN, take 10'h3F0, in_service=2'b11; two retis -> 2'b10 then 2'b00 and IDLE.
- Hold intr1 high for 20 cycles -> exactly one take. New intr1 edge during TAKE -> pending[0] stays 1.
- Assert reset during SERVE with pending=2'b10 -> all outputs 0 asynchronously. After release, reti and no intr lines -> no take.
